complex_rot_quadrant_pipe_32b: RTL and testbench

- Streaming quadrant rotator: multiplies a packed complex sample by (-j)^k in forward mode or (+j)^k in inverse mode (IFFT), k = 0..3.
- Inverse-direction counterpart of the fixed forward -j twiddle stage. Replaces combinational rotators with a registered, back-pressurable 2-stage pipe.
- Sits between butterfly stages of the 64-point FFT/IFFT datapath.
- Tracks sample index within a 64-point frame.

---
 rtl/complex_rot_quadrant_pipe_32b.sv | 144 ++++++++++++++
 tb/tb_complex_rot_quadrant_pipe_32b.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_rot_quadrant_pipe_32b.sv
// Streaming quadrant rotator: out = in * (-j)^k (forward) or (+j)^k (inverse), 2-stage registered pipe.
// Optional COMPLEX_ROT_SAT_NEG_EN: saturating negation with a sticky sat_flag.
module complex_rot_quadrant_pipe_32b #(
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_quad,
  input  logic        in_inv,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        sat_flag
);
  localparam int unsigned DW = 32;
  localparam int unsigned HW = 16;
  localparam int unsigned CW = 6;
  localparam int unsigned EW = 2;

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [EW-1:0] s1_exp_q, s1_exp_d;
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic [CW-1:0] idx_q, idx_d;

  logic          s2_adv;
  logic          out_fire;
  logic [HW-1:0] rot_a, rot_b, neg_a, neg_b;
  logic [DW-1:0] rot_data;

  assign rot_a = s1_data_q[DW-1:HW];
  assign rot_b = s1_data_q[HW-1:0];

`ifdef COMPLEX_ROT_SAT_NEG_EN
  logic sat_a, sat_b, rot_sat;
  logic s2_sat_q, s2_sat_d;
  logic sat_flag_q, sat_flag_d;

  // -(-32768) clamps to +32767 instead of wrapping
  assign sat_a = (rot_a == 16'h8000);
  assign sat_b = (rot_b == 16'h8000);
  assign neg_a = sat_a ? 16'h7FFF : HW'(16'd0 - rot_a);
  assign neg_b = sat_b ? 16'h7FFF : HW'(16'd0 - rot_b);

  always_comb begin
    rot_sat = 1'b0;
    case (s1_exp_q)
      2'd1:    rot_sat = sat_a;
      2'd2:    rot_sat = sat_a | sat_b;
      2'd3:    rot_sat = sat_b;
      default: rot_sat = 1'b0;
    endcase
  end

  always_comb begin
    s2_sat_d   = s2_sat_q;
    sat_flag_d = sat_flag_q;
    if (s2_adv && s1_valid_q) s2_sat_d = rot_sat;
    if (out_fire && s2_sat_q) sat_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sat_q   <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      s2_sat_q   <= s2_sat_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
`else
  assign neg_a    = HW'(16'd0 - rot_a);
  assign neg_b    = HW'(16'd0 - rot_b);
  assign sat_flag = 1'b0;
`endif

  // Multiply by (-j)^e: each quarter turn maps (a, b) -> (b, -a)
  always_comb begin
    rot_data = s1_data_q;
    case (s1_exp_q)
      2'd0:    rot_data = {rot_a, rot_b};
      2'd1:    rot_data = {rot_b, neg_a};
      2'd2:    rot_data = {neg_a, neg_b};
      default: rot_data = {neg_b, rot_a};
    endcase
  end

  // Pipe control: each stage loads when empty or when its successor is moving
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_adv;
    out_fire   = s2_valid_q && out_ready;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_exp_d   = s1_exp_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    idx_d      = idx_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_exp_d  = in_inv ? EW'(2'd0 - in_quad) : in_quad;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_data_d = rot_data;
    end
    if (out_fire) begin
      idx_d = (idx_q == CW'(FRAME_LEN - 1)) ? '0 : idx_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      idx_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_exp_q   <= s1_exp_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      idx_q      <= idx_d;
    end
  end

  assign out_data  = s2_data_q;
  assign out_valid = s2_valid_q;
  assign out_last  = s2_valid_q && (idx_q == CW'(FRAME_LEN - 1));

endmodule

// File: tb/tb_complex_rot_quadrant_pipe_32b.sv
// Scoreboard bench for complex_rot_quadrant_pipe_32b: directed vectors, back-pressure, framing, reset.
module tb_complex_rot_quadrant_pipe_32b;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_quad = '0;
  logic        in_inv = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        sat_flag;

  complex_rot_quadrant_pipe_32b #(.FRAME_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_quad(in_quad), .in_inv(in_inv),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          out_cnt = 0;
  int          last_cnt = 0;
  logic        exp_sat = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

`ifdef COMPLEX_ROT_SAT_NEG_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference via complex multiply by the twiddle (wr + j*wi), then wrap or clamp to 16 bits
  function automatic exp_t ref_rot(input logic [31:0] d, input logic [1:0] q, input logic inv);
    exp_t r;
    int a, b, wr, wi, re, im;
    logic s;
    a = int'($signed(d[31:16]));
    b = int'($signed(d[15:0]));
    case (q)
      2'd0: begin wr = 1;  wi = 0; end
      2'd1: begin wr = 0;  wi = inv ? 1 : -1; end
      2'd2: begin wr = -1; wi = 0; end
      default: begin wr = 0; wi = inv ? -1 : 1; end
    endcase
    re = a * wr - b * wi;
    im = a * wi + b * wr;
    s = 1'b0;
    if (SAT_EN) begin
      if (re > 32767) begin re = 32767; s = 1'b1; end
      if (im > 32767) begin im = 32767; s = 1'b1; end
    end
    r.data = {16'(re), 16'(im)};
    r.sat  = s;
    return r;
  endfunction

  // Drive one sample (caller sits at posedge+1); returns at posedge+1 after its handshake
  task automatic send(input logic [31:0] d, input logic [1:0] q, input logic inv,
                      input logic [31:0] exp_d, input logic exp_s);
    int  c;
    bit  done;
    exp_t e;
    in_data = d; in_quad = q; in_inv = inv; in_valid = 1'b1;
    c = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = exp_d; e.sat = exp_s;
        sb_q.push_back(e);
        done = 1;
      end else if (c >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", c);
        done = 1;
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_ref(input logic [31:0] d, input logic [1:0] q, input logic inv);
    exp_t e;
    e = ref_rot(d, q, inv);
    send(d, q, inv, e.data, e.sat);
  endtask

  task automatic drain();
    int c;
    in_valid = 1'b0; out_ready = 1'b1;
    c = 0;
    while (sb_q.size() != 0 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_remaining", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: pops expectations on every output handshake, checks stall stability and sat_flag
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      out_cnt    = 0;
      last_cnt   = 0;
      exp_sat    = 1'b0;
    end else begin
      check("sat_flag", 32'(sat_flag), 32'(exp_sat));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got 0x%08h with no sample pending", out_data);
        end else begin
          e = sb_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", 32'(out_last), 32'((out_cnt % 64) == 63));
          if (out_last) last_cnt++;
          exp_sat = exp_sat | e.sat;
          out_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    bit seen_block;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);

    // Forward rotation with latency check
    send(32'h1234_F000, 2'd1, 1'b0, 32'hF000_EDCC, 1'b0);
    in_valid = 1'b0;
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_data", out_data, 32'hF000_EDCC);
    @(posedge clk); #1;
    check("lat_cycle3_valid", 32'(out_valid), 32'd0);

    // Remaining quadrants, both directions
    send(32'h1234_F000, 2'd1, 1'b1, 32'h1000_1234, 1'b0);
    send(32'h1234_F000, 2'd2, 1'b0, 32'hEDCC_1000, 1'b0);
    send(32'h1234_F000, 2'd2, 1'b1, 32'hEDCC_1000, 1'b0);
    send(32'h1234_F000, 2'd0, 1'b0, 32'h1234_F000, 1'b0);
    send(32'h1234_F000, 2'd0, 1'b1, 32'h1234_F000, 1'b0);
    send(32'h1234_F000, 2'd3, 1'b0, 32'h1000_1234, 1'b0);
    send(32'h1234_F000, 2'd3, 1'b1, 32'hF000_EDCC, 1'b0);
    drain();

    // Back-pressure: 8-sample stream with out_ready low for 5 cycles
    seen_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_ref(32'h0101_0202 * 32'(i + 1), 2'(i), i[2]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (in_valid && !in_ready) seen_block = 1'b1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    check("bp_in_ready_dropped", 32'(seen_block), 32'd1);
    drain();

    // Frame marker over 130 continuous samples
    do_reset();
    for (int i = 0; i < 130; i++)
      send_ref(32'(i) * 32'h9E37_79B1, 2'(i), i[2]);
    drain();
    check("frame_last_count", 32'(last_cnt), 32'd2);
    check("frame_out_count", 32'(out_cnt), 32'd130);

    // Negation boundary and sticky sat_flag
    send(32'h8000_0001, 2'd1, 1'b0, SAT_EN ? 32'h0001_7FFF : 32'h0001_8000, SAT_EN);
    drain();
    check("bound_sat_flag", 32'(sat_flag), 32'(SAT_EN));
    send(32'h8000_8000, 2'd2, 1'b1, SAT_EN ? 32'h7FFF_7FFF : 32'h8000_8000, SAT_EN);
    send(32'h0005_0007, 2'd0, 1'b0, 32'h0005_0007, 1'b0);
    drain();
    check("bound_sat_sticky", 32'(sat_flag), 32'(SAT_EN));

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send_ref(32'hAAAA_5555, 2'd1, 1'b0);
    send_ref(32'h1111_2222, 2'd3, 1'b1);
    in_valid = 1'b0;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_sat", 32'(sat_flag), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++)
      send_ref(32'h3C3C_0F0F + 32'(i * 257), 2'(i + 1), i[0]);
    drain();
    check("mid_last_count", 32'(last_cnt), 32'd1);
    check("mid_out_count", 32'(out_cnt), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
